// File: rtl/aes_decrypt_iter_if.sv
// Valid/ready bundle for the iterative AES-128 decryption core.
//   in_valid / in_ready / in_new_key / in_key / in_data : ciphertext + key input side
//   out_valid / out_ready / out_data                    : plaintext output side
//   busy                                                : core is not idle
// master = the block driving ciphertext and accepting plaintext; slave = the core.
interface aes_decrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_new_key;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_new_key, in_key, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_new_key, in_key, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption: one inverse round per clock on a shared datapath.
// Round keys are produced on the fly: forward expansion key -> rk10, then inverse
// expansion rk10 -> rk0 alongside the rounds. Optional cache of the last rk10.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : aes_decrypt_iter_if.slave (ciphertext/key in, plaintext out, busy)
// Parameter KEY_CACHE: 1 keeps rk10 of the last expanded key, 0 always expands.
module aes_decrypt_iter #(
  parameter int KEY_CACHE = 1
) (
  input logic               clk,
  input logic               rst_n,
  aes_decrypt_iter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} fsm_t;

  fsm_t         fsm_state, fsm_next;
  logic [127:0] state_reg, rk_reg, cache_reg, out_data_reg;
  logic         cache_vld;
  logic [3:0]   cnt;

  // ---------------- GF(2^8) arithmetic, polynomial 0x11B ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 (and 0 maps to 0): accumulate a^2 * a^4 * ... * a^128.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-boxes computed from the field inverse and the affine map, not tabulated.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // rcon for round i (1..10): 01,02,04,...,80,1b,36
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < 10; k++)
      if (k < int'(i)) r = xtime(r);
    return r;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] fwd_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_rot(rk[31:0]) ^ {rc, 24'h0};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one expansion step; w0' needs the recovered w3', hence the ordering.
  function automatic logic [127:0] inv_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = rk[31:0]  ^ rk[63:32];
    n2 = rk[63:32] ^ rk[95:64];
    n1 = rk[95:64] ^ rk[127:96];
    n0 = rk[127:96] ^ sub_rot(n3) ^ {rc, 24'h0};
    return {n0, n1, n2, n3};
  endfunction

  // InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns.
  // Byte k = row + 4*col lives at bits [127-8k -: 8].
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [127:0] t, o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]);
    t = t ^ rk;
    o = t;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        {a0, a1, a2, a3} = t[127 - 32*c -: 32];
        o[127 - 32*c -: 32] = {
          gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
          gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
          gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
          gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
      end
    end
    return o;
  endfunction

  // ---------------- shared datapath ----------------
  logic         accept, need_exp;
  logic [127:0] rk_next, rk_prev, round_out;

  assign accept    = bus.in_valid && (fsm_state == IDLE);
  assign need_exp  = bus.in_new_key || !cache_vld || (KEY_CACHE == 0);
  assign rk_next   = fwd_expand(rk_reg, rcon(cnt));
  assign rk_prev   = inv_expand(rk_reg, rcon(cnt));
  assign round_out = inv_round(state_reg, rk_prev, cnt != 4'd1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) fsm_state <= IDLE;
    else        fsm_state <= fsm_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    // NOTE: default first so no path leaves fsm_next unassigned (no latch).
    fsm_next = fsm_state;
    case (fsm_state)
      IDLE:    if (accept) fsm_next = need_exp ? KEYEXP : INIT;
      KEYEXP:  if (cnt == 4'd10) fsm_next = INIT;
      INIT:    fsm_next = ROUND;
      ROUND:   if (cnt == 4'd1) fsm_next = DONE;
      DONE:    if (bus.out_ready) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.in_ready  = (fsm_state == IDLE);
    bus.busy      = (fsm_state != IDLE);
    bus.out_valid = (fsm_state == DONE);
    bus.out_data  = out_data_reg;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= '0;
      rk_reg       <= '0;
      cache_reg    <= '0;
      cache_vld    <= 1'b0;
      out_data_reg <= '0;
      cnt          <= '0;
    end else begin
      case (fsm_state)
        IDLE: if (accept) begin
          state_reg <= bus.in_data;
          rk_reg    <= need_exp ? bus.in_key : cache_reg;
          cnt       <= 4'd1;
        end
        KEYEXP: begin
          rk_reg <= rk_next;
          if (cnt == 4'd10) begin
            cache_reg <= rk_next;
            cache_vld <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        INIT: begin
          state_reg <= state_reg ^ rk_reg;
          cnt       <= 4'd10;
        end
        ROUND: begin
          rk_reg    <= rk_prev;
          state_reg <= round_out;
          if (cnt == 4'd1) out_data_reg <= round_out;
          else             cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
